// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: channel map and default sizes.
package perf_pkg;

  localparam int unsigned PERF_NUM_CH_DEFAULT = 6;
  localparam int unsigned PERF_CNT_W_DEFAULT  = 32;

  localparam int unsigned PERF_CH_INST  = 0;
  localparam int unsigned PERF_CH_ICREQ = 1;
  localparam int unsigned PERF_CH_ICHIT = 2;
  localparam int unsigned PERF_CH_DCREQ = 3;
  localparam int unsigned PERF_CH_DCHIT = 4;
  localparam int unsigned PERF_CH_HALT  = 5;

  // Select width for a bank of n channels; never narrower than one bit.
  function automatic int unsigned perf_sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_ctr.sv
// Single event counter with synchronous clear and a sticky wrap flag.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W = PERF_CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  // Flag rises on the same edge the count wraps from all-ones to zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (&r_cnt) r_ovf <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/perf_counter_bank.sv
// Event counter bank with freeze-on-halt and a registered read port.
// Optional shadow bank selected by PERF_SNAPSHOT_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned NUM_CH = PERF_NUM_CH_DEFAULT,
  parameter int unsigned CNT_W  = PERF_CNT_W_DEFAULT,
  parameter int unsigned SEL_W  = perf_sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [NUM_CH-1:0] ev,
  input  logic              halt,
  input  logic              snap,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_shadow,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              frozen
);

  logic [CNT_W-1:0]  w_cnt [NUM_CH];
  logic [NUM_CH-1:0] w_inc;
  logic              w_cnt_en;
  logic              w_cyc_ovf_unused;
  logic              r_frozen;
  logic              r_rd_valid;
  logic [CNT_W-1:0]  r_rd_data;
  logic [CNT_W-1:0]  w_rd_data_c;

  assign w_cnt_en = en & ~r_frozen & ~clr;
  assign w_inc    = ev & {NUM_CH{w_cnt_en}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_ctr #(.CNT_W(CNT_W)) u_ctr (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (clr),
      .i_inc (w_inc[g]),
      .o_cnt (w_cnt[g]),
      .o_ovf (ovf[g])
    );
  end

  // Cycle counter wraps silently; its flag is not exported.
  perf_ctr #(.CNT_W(CNT_W)) u_cyc (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (clr),
    .i_inc (w_cnt_en),
    .o_cnt (cycle_count),
    .o_ovf (w_cyc_ovf_unused)
  );

  // Freeze is registered from halt; only clr or reset releases it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frozen <= 1'b0;
    end else if (clr) begin
      r_frozen <= 1'b0;
    end else if (halt) begin
      r_frozen <= 1'b1;
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shadow [NUM_CH+1];
  logic             w_take;

  assign w_take = snap | (halt & ~r_frozen & ~clr);

  // Shadow captures post-update values; clr does not touch it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= NUM_CH; i++) r_shadow[i] <= '0;
    end else if (w_take) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= clr ? '0 : w_cnt[i] + CNT_W'(w_inc[i]);
      end
      r_shadow[NUM_CH] <= clr ? '0 : cycle_count + CNT_W'(w_cnt_en);
    end
  end

  always_comb begin
    w_rd_data_c = '0;
    if (rd_shadow) begin
      for (int unsigned i = 0; i <= NUM_CH; i++) begin
        if (32'(rd_sel) == i) w_rd_data_c = r_shadow[i];
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (32'(rd_sel) == i) w_rd_data_c = w_cnt[i];
      end
    end
  end
`else
  logic w_snap_unused;
  assign w_snap_unused = snap | rd_shadow;

  always_comb begin
    w_rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_sel) == i) w_rd_data_c = w_cnt[i];
    end
  end
`endif

  // Read returns pre-update counter values one cycle after the request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_data_c;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign frozen   = r_frozen;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank (NUM_CH=6, CNT_W=8) against a behavioural model.
module tb_perf_counter_bank;

  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int MOD = 256;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0, clr = 1'b0, halt = 1'b0, snap = 1'b0;
  logic [NCH-1:0] ev = '0;
  logic           rd_req = 1'b0, rd_shadow = 1'b0;
  logic [2:0]     rd_sel = '0;
  logic           rd_valid;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] ovf;
  logic [CW-1:0]  cycle_count;
  logic           frozen;

  perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .ev (ev), .halt (halt),
    .snap (snap), .rd_req (rd_req), .rd_sel (rd_sel), .rd_shadow (rd_shadow),
    .rd_valid (rd_valid), .rd_data (rd_data), .ovf (ovf),
    .cycle_count (cycle_count), .frozen (frozen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference state: plain integers, counted per the count/halt/clear rules.
  int       m_cnt [NCH];
  int       m_cyc;
  bit [5:0] m_ovf;
  bit       m_frz;
  int       m_sh [NCH+1];
  bit       m_valid;
  int       m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_read(input bit [2:0] sel, input bit sh);
`ifdef PERF_SNAPSHOT_EN
    if (sh) return (int'(sel) <= NCH) ? m_sh[sel] : 0;
`endif
    return (int'(sel) < NCH) ? m_cnt[sel] : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(m_valid));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(m_data));
    chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(m_cyc));
    chk({tag, "_frozen"}, 64'(frozen), 64'(m_frz));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    for (int i = 0; i <= NCH; i++) m_sh[i] = 0;
    m_cyc = 0; m_ovf = '0; m_frz = 0; m_valid = 0; m_data = 0;
  endtask

  // Reset with a read in flight: the read must be dropped.
  task automatic do_reset(input string tag);
    rst = 1'b0; rd_req = 1'b1; rd_sel = 3'd0; ev = '1; en = 1'b1;
    clr = 1'b0; halt = 1'b0; snap = 1'b0; rd_shadow = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1; rd_req = 1'b0;
    check_all(tag);
  endtask

  task automatic step(input bit [5:0] e, input bit en_i, input bit clr_i, input bit halt_i,
                      input bit snap_i, input bit rd_i, input bit [2:0] sel_i, input bit sh_i,
                      input string tag);
    bit was_frz;
    ev = e; en = en_i; clr = clr_i; halt = halt_i; snap = snap_i;
    rd_req = rd_i; rd_sel = sel_i; rd_shadow = sh_i; rst = 1'b1;
    m_valid = rd_i;
    if (rd_i) m_data = model_read(sel_i, sh_i);
    was_frz = m_frz;
    if (clr_i) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      m_cyc = 0; m_ovf = '0; m_frz = 0;
    end else begin
      if (en_i && !was_frz) begin
        for (int i = 0; i < NCH; i++) begin
          if (e[i]) begin
            m_cnt[i] = (m_cnt[i] + 1) % MOD;
            if (m_cnt[i] == 0) m_ovf[i] = 1'b1;
          end
        end
        m_cyc = (m_cyc + 1) % MOD;
      end
      if (halt_i) m_frz = 1'b1;
    end
`ifdef PERF_SNAPSHOT_EN
    if (snap_i || (halt_i && !was_frz && !clr_i)) begin
      for (int i = 0; i < NCH; i++) m_sh[i] = m_cnt[i];
      m_sh[NCH] = m_cyc;
    end
`endif
    @(posedge clk); #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [5:0] ev;
    logic       en;
    logic       rd;
    logic [2:0] sel;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_cyc;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mkrow(input logic [5:0] e, input logic en_i, input logic rd_i,
                                 input logic [2:0] sel_i, input logic v, input logic [7:0] d,
                                 input logic [7:0] c);
    vec_t r;
    r.ev = e; r.en = en_i; r.rd = rd_i; r.sel = sel_i;
    r.exp_valid = v; r.exp_data = d; r.exp_cyc = c;
    return r;
  endfunction

  initial begin
    logic [5:0] e;
    // Ten counting cycles: ch0 on even cycles (5), ch1 on the first four (4).
    for (int i = 0; i < 10; i++) begin
      e = '0;
      e[0] = (i % 2 == 0);
      e[1] = (i < 4);
      tbl[i] = mkrow(e, 1'b1, 1'b0, 3'd0, 1'b0, 8'd0, 8'(i + 1));
    end
    tbl[10] = mkrow(6'd0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd5, 8'd10);
    tbl[11] = mkrow(6'd0, 1'b0, 1'b1, 3'd7, 1'b1, 8'd0, 8'd10);
    tbl[12] = mkrow(6'd0, 1'b0, 1'b1, 3'd0, 1'b1, 8'd5, 8'd10);
    tbl[13] = mkrow(6'd0, 1'b0, 1'b1, 3'd1, 1'b1, 8'd4, 8'd10);
    tbl[14] = mkrow(6'd0, 1'b0, 1'b0, 3'd0, 1'b0, 8'd4, 8'd10);

    model_reset();
    @(posedge clk); #1;
    do_reset("reset");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].ev, tbl[i].en, 1'b0, 1'b0, 1'b0, tbl[i].rd, tbl[i].sel, 1'b0, "tbl");
      chk($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_data", i), 64'(rd_data), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_cyc", i), 64'(cycle_count), 64'(tbl[i].exp_cyc));
    end

    // Wrap on ch2 after 256 events.
    step(6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "wrap_clr");
    for (int i = 0; i < 256; i++) step(6'b000100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "wrap");
    chk("wrap_ovf_only_ch2", 64'(ovf), 64'(6'b000100));
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, "wrap_rd");
    chk("wrap_ch2_zero", 64'(rd_data), 64'd0);
    step(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "wrap_clr2");
    chk("wrap_ovf_cleared", 64'(ovf), 64'd0);

    // Halt freeze: ev[1] continuous, halt on the seventh cycle.
    for (int i = 1; i <= 7; i++) step(6'b000010, 1'b1, 1'b0, (i == 7), 1'b0, 1'b0, 3'd0, 1'b0, "halt");
    chk("halt_frozen", 64'(frozen), 64'd1);
    for (int i = 0; i < 20; i++) step(6'b000010, 1'b1, 1'b0, (i == 5), 1'b0, 1'b0, 3'd0, 1'b0, "halt_hold");
    step(6'b000010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, "halt_rd");
    chk("halt_ch1_seven", 64'(rd_data), 64'd7);
    step(6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "halt_clr");
    chk("halt_unfrozen", 64'(frozen), 64'd0);

    // clr, event and read on ch0 in the same cycle.
    for (int i = 0; i < 3; i++) step(6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "sim");
    step(6'b000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, "sim_clr");
    chk("sim_preclear_read", 64'(rd_data), 64'd3);
    chk("sim_halt_ignored", 64'(frozen), 64'd0);
    step(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "sim_rd");
    chk("sim_ch0_cleared", 64'(rd_data), 64'd0);

`ifdef PERF_SNAPSHOT_EN
    step(6'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "snap_clr");
    for (int i = 0; i < 4; i++) step(6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "snap_pre");
    step(6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, "snap");
    for (int i = 0; i < 2; i++) step(6'b000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, "snap_post");
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, "snap_rd_sh");
    chk("snap_shadow_ch0", 64'(rd_data), 64'd4);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, "snap_rd_live");
    chk("snap_live_ch0", 64'(rd_data), 64'd6);
    step(6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, "snap_rd_cyc");
    chk("snap_shadow_cyc", 64'(rd_data), 64'd5);
`endif

    // Randomized traffic against the model, with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rnd_reset");
      end else begin
        step(6'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 59) == 0),
             ($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
             1'($urandom), 3'($urandom), 1'($urandom), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
